// File: rtl/pool_window_sched.sv
// pool_window_sched: turns a raster-order stream of convolution results into a
// stream of 2x2 stride-2 max-pooled values. One even row is buffered; the odd
// row completes each window, which is reduced by a max_pooling instance.

module max_pooling #(
    parameter int unsigned DW = 36
) (
    input  logic [DW-1:0] conv_val0,
    input  logic [DW-1:0] conv_val1,
    input  logic [DW-1:0] conv_val2,
    input  logic [DW-1:0] conv_val3,
    output logic [DW-1:0] max_val
);

    logic [DW-1:0] max_top;
    logic [DW-1:0] max_bot;

    // Unsigned tree reduction of the four window values
    always_comb begin
        max_top = (conv_val0 > conv_val1) ? conv_val0 : conv_val1;
        max_bot = (conv_val2 > conv_val3) ? conv_val2 : conv_val3;
        max_val = (max_top > max_bot) ? max_top : max_bot;
    end

endmodule

module pool_window_sched #(
    parameter int unsigned MAP_W = 4,
    parameter int unsigned MAP_H = 4,
    parameter int unsigned DW    = 36
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);

    localparam int unsigned CW = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int unsigned RW = (MAP_H > 1) ? $clog2(MAP_H) : 1;

    // Windows are non-overlapping 2x2, so odd dimensions have no valid tiling
    if ((MAP_W % 2) != 0 || MAP_W < 2) begin : g_bad_map_w
        $error("pool_window_sched: MAP_W must be even and >= 2");
    end
    if ((MAP_H % 2) != 0 || MAP_H < 2) begin : g_bad_map_h
        $error("pool_window_sched: MAP_H must be even and >= 2");
    end

    // Phase within the 2x2 tiling, fully encoded by row[0]/col[0]
    typedef enum logic [1:0] {
        StFillTop = 2'd0,
        StHoldBl  = 2'd1,
        StEmit    = 2'd2
    } phase_e;

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [DW-1:0] hold_q;
    logic          busy_q;
    logic [DW-1:0] linebuf [MAP_W];

    phase_e        phase;
    logic          accept;
    logic          emit;
    logic          col_wrap;
    logic          row_wrap;
    logic          frame_end;
    logic [CW-1:0] col_left;
    logic [DW-1:0] max_val;

    // Decode phase and the per-sample control strobes
    always_comb begin
        if (!row_q[0]) begin
            phase = StFillTop;
        end else if (!col_q[0]) begin
            phase = StHoldBl;
        end else begin
            phase = StEmit;
        end
        accept    = in_valid && !clear;
        emit      = accept && (phase == StEmit);
        col_wrap  = (col_q == CW'(MAP_W - 1));
        row_wrap  = (row_q == RW'(MAP_H - 1));
        frame_end = emit && col_wrap && row_wrap;
        col_left  = col_q - CW'(1);
    end

    max_pooling #(
        .DW (DW)
    ) u_max_pooling (
        .conv_val0 (linebuf[col_left]),
        .conv_val1 (linebuf[col_q]),
        .conv_val2 (hold_q),
        .conv_val3 (in_data),
        .max_val   (max_val)
    );

    // Top row of each window; no reset since every entry is written before it is read
    always_ff @(posedge clk) begin
        if (accept && (phase == StFillTop)) begin
            linebuf[col_q] <= in_data;
        end
    end

    // Counters, bottom-left hold, registered pooled output and frame-busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q     <= '0;
            row_q     <= '0;
            hold_q    <= '0;
            busy_q    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            // Abort the frame; an output completing on this edge is dropped
            col_q     <= '0;
            row_q     <= '0;
            busy_q    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= emit;
            out_last  <= frame_end;
            if (accept) begin
                busy_q <= !frame_end;
                if (phase == StHoldBl) begin
                    hold_q <= in_data;
                end
                if (emit) begin
                    out_data <= max_val;
                end
                if (col_wrap) begin
                    col_q <= '0;
                    row_q <= row_wrap ? '0 : row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

    // The next frame's first sample arriving alongside out_last keeps busy high
    always_comb begin
        busy = busy_q || (out_last && in_valid && !clear);
    end

endmodule

// File: tb/tb_pool_window_sched.sv
// Scoreboard bench for pool_window_sched (4x4 map, 36-bit samples).

module tb_pool_window_sched;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned DW = 36;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    pool_window_sched #(
        .MAP_W (W),
        .MAP_H (H),
        .DW    (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        bit            l;
    } exp_t;

    exp_t          sbq [$];
    logic [DW-1:0] got [$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            mrow = 0;
    int            mcol = 0;
    logic [DW-1:0] mlb [W];
    logic [DW-1:0] mhold;
    bit            mbsy  = 0;
    bit            exp_v = 0;
    bit            exp_l = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, b, c, d);
        logic [DW-1:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // One clock: drive, check busy mid-cycle, clock in, advance the model
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit clr);
        exp_t e;
        in_valid = v;
        in_data  = d;
        clear    = clr;
        @(negedge clk);
        check("busy", busy, mbsy || (exp_v && exp_l && v && !clr));
        @(posedge clk);
        exp_v = 0;
        exp_l = 0;
        if (clr) begin
            mrow = 0;
            mcol = 0;
            mbsy = 0;
        end else if (v) begin
            if (mrow % 2 == 0) begin
                mlb[mcol] = d;
            end else if (mcol % 2 == 0) begin
                mhold = d;
            end else begin
                e.d = max4(mlb[mcol-1], mlb[mcol], mhold, d);
                e.l = (mrow == H - 1) && (mcol == W - 1);
                sbq.push_back(e);
                exp_v = 1;
                exp_l = e.l;
            end
            mbsy = !(exp_v && exp_l);
            if (mcol == W - 1) begin
                mcol = 0;
                mrow = (mrow == H - 1) ? 0 : mrow + 1;
            end else begin
                mcol = mcol + 1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
    endtask

    // Frame of values base+1..base+16, optionally with random stall gaps
    task automatic frame(input int base, input bit gaps);
        for (int i = 1; i <= W * H; i++) begin
            if (gaps) begin
                while ($urandom % 2 == 1) cycle(1'b0, '0, 1'b0);
            end
            cycle(1'b1, DW'(base + i), 1'b0);
        end
    endtask

    // Four pooled results of a 1..16-style frame starting at got[idx]
    task automatic check_four(input int idx, input int base);
        logic [DW-1:0] e [4];
        e[0] = DW'(base + 6);
        e[1] = DW'(base + 8);
        e[2] = DW'(base + 14);
        e[3] = DW'(base + 16);
        check("result_count_min", 64'(got.size() >= idx + 4), 64'(1));
        if (got.size() >= idx + 4) begin
            for (int k = 0; k < 4; k++) check("result_value", got[idx+k], e[k]);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        mrow  = 0;
        mcol  = 0;
        mbsy  = 0;
        exp_v = 0;
        exp_l = 0;
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Output monitor: pulse timing against the model, data against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", out_valid, exp_v);
            check("out_last", out_last, exp_l);
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    check("sb_unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("out_data", out_data, e.d);
                    got.push_back(out_data);
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] ud [16];
        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Continuous 1..16
        got.delete();
        frame(0, 1'b0);
        idle(3);
        check_four(0, 0);
        check("out_data_hold", out_data, 16);
        check("busy_idle", busy, 0);

        // Unsigned compare window
        for (int i = 0; i < 16; i++) ud[i] = DW'(i + 1);
        ud[0] = 36'h123456789;
        ud[1] = 36'h987654321;
        ud[4] = 36'h111111111;
        ud[5] = 36'h0FFFFFFFF;
        got.delete();
        for (int i = 0; i < 16; i++) cycle(1'b1, ud[i], 1'b0);
        idle(2);
        check("unsigned_count", 64'(got.size()), 4);
        if (got.size() > 0) check("unsigned_max", got[0], 36'h987654321);

        // Random stall gaps
        got.delete();
        frame(0, 1'b1);
        idle(3);
        check_four(0, 0);
        check("gap_count", 64'(got.size()), 4);

        // Clear with a simultaneous sample that would have completed a window
        got.delete();
        for (int i = 1; i <= 7; i++) cycle(1'b1, DW'(i), 1'b0);
        cycle(1'b1, DW'(8), 1'b1);
        idle(2);
        check("clear_busy", busy, 0);
        got.delete();
        frame(0, 1'b0);
        idle(2);
        check_four(0, 0);
        check("clear_count", 64'(got.size()), 4);

        // Asynchronous reset mid-frame
        for (int i = 1; i <= 10; i++) cycle(1'b1, DW'(i), 1'b0);
        do_reset();
        got.delete();
        frame(0, 1'b0);
        idle(2);
        check_four(0, 0);
        check("reset_count", 64'(got.size()), 4);

        // Back-to-back frames
        got.delete();
        frame(0, 1'b0);
        frame(16, 1'b0);
        idle(3);
        check_four(0, 0);
        check_four(4, 16);
        check("b2b_count", 64'(got.size()), 8);
        check("sb_drained", 64'(sbq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
